// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decryption, one Feistel round per clock.
// Subkeys K16..K1 are produced by right-rotating the PC-1 key halves.

module des_sbox #(
  parameter logic [255:0] TABLE = '0
) (
  input  logic [5:0] DataIn,
  output logic [3:0] DataOut
);
  logic [5:0] idx;

  // Row is the outer bit pair, column the middle four bits.
  assign idx = {DataIn[5], DataIn[0], DataIn[4:1]};
  assign DataOut = TABLE[8'd255 - {idx, 2'b00} -: 4];
endmodule

module des_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [63:0] Key,
  input  logic [63:0] CipherIn,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] PlainOut
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINISH
  } state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [255:0] SBOX_T [8] = '{
    {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
     64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
     64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
     64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
     64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
     64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
     64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
     64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
     64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++)
      y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++)
      y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++)
      y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] f_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++)
      y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++)
      y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++)
      y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [27:0] f_rotr(
    input logic [27:0] x,
    input logic [1:0]  n
  );
    logic [27:0] y;
    unique case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [63:0] pt_q, pt_d;
  logic        done_q, done_d;

  logic [1:0]  rot_amt;
  logic [27:0] c_rot, d_rot;
  logic [47:0] sub_key, s_in;
  logic [31:0] s_out, f_out;

  // Decrypt order: K16 uses the unrotated halves, then undo each left shift.
  always_comb begin
    unique case (rnd_q)
      4'd0:                rot_amt = 2'd0;
      4'd1, 4'd8, 4'd15:   rot_amt = 2'd1;
      default:             rot_amt = 2'd2;
    endcase
  end

  assign c_rot   = f_rotr(c_q, rot_amt);
  assign d_rot   = f_rotr(d_q, rot_amt);
  assign sub_key = f_pc2({c_rot, d_rot});
  assign s_in    = f_e(r_q) ^ sub_key;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    des_sbox #(.TABLE(SBOX_T[g])) u_sbox (
      .DataIn  (s_in[47 - 6*g -: 6]),
      .DataOut (s_out[31 - 4*g -: 4])
    );
  end

  assign f_out = f_p(s_out);

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    c_d     = c_q;
    d_d     = d_q;
    rnd_d   = rnd_q;
    pt_d    = pt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d    = S_ROUND;
          {l_d, r_d} = f_ip(CipherIn);
          {c_d, d_d} = f_pc1(Key);
          rnd_d      = 4'd0;
        end
      end
      S_ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        c_d   = c_rot;
        d_d   = d_rot;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd15)
          state_d = S_FINISH;
      end
      S_FINISH: begin
        pt_d    = f_fp({r_q, l_q});
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      rnd_q   <= '0;
      pt_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rnd_q   <= rnd_d;
      pt_q    <= pt_d;
      done_q  <= done_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;
  assign PlainOut = pt_q;
endmodule
